// File: rtl/rrx_stream_pkg.sv
// Shared types and helpers for the RRX framebuffer stream path.
package rrx_stream_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } unpack_state_t;

  function automatic int pixels_per_word(input int stream_w, input int pixel_w);
    return stream_w / pixel_w;
  endfunction

endpackage

// File: rtl/framebuffer_stream_unpacker_pixel_position_counter.sv
// Raster position tracker: x/y counters plus line-end / frame-start / frame-end flags.
module pixel_position_counter #(
  parameter int X_RESOLUTION = 128,
  parameter int Y_RESOLUTION = 128
) (
  input  logic aclk,
  input  logic rst,
  input  logic advance,
  input  logic resync,
  output logic at_line_end,
  output logic at_frame_start,
  output logic at_frame_end
);

  localparam int XW = (X_RESOLUTION > 1) ? $clog2(X_RESOLUTION) : 1;
  localparam int YW = (Y_RESOLUTION > 1) ? $clog2(Y_RESOLUTION) : 1;
  localparam logic [XW-1:0] X_MAX = XW'(X_RESOLUTION - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(Y_RESOLUTION - 1);

  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;

  always_ff @(posedge aclk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else if (advance) begin
      // A misplaced input tlast snaps the raster back to the frame origin.
      if (resync) begin
        x_q <= '0;
        y_q <= '0;
      end else if (x_q == X_MAX) begin
        x_q <= '0;
        y_q <= (y_q == Y_MAX) ? '0 : y_q + YW'(1);
      end else begin
        x_q <= x_q + XW'(1);
      end
    end
  end

  assign at_line_end    = (x_q == X_MAX);
  assign at_frame_start = (x_q == '0) && (y_q == '0);
  assign at_frame_end   = (x_q == X_MAX) && (y_q == Y_MAX);

endmodule

// File: rtl/framebuffer_stream_unpacker.sv
// Splits packed framebuffer words into one RGB565 pixel per cycle with raster markers.
module framebuffer_stream_unpacker
  import rrx_stream_pkg::*;
#(
  parameter int CMD_STREAM_WIDTH = 32,
  parameter int PIXEL_WIDTH      = 16,
  parameter int X_RESOLUTION     = 128,
  parameter int Y_RESOLUTION     = 128
) (
  input  logic                        aclk,
  input  logic                        rst,
  input  logic                        s_framebuffer_axis_tvalid,
  output logic                        s_framebuffer_axis_tready,
  input  logic                        s_framebuffer_axis_tlast,
  input  logic [CMD_STREAM_WIDTH-1:0] s_framebuffer_axis_tdata,
  output logic                        m_pixel_axis_tvalid,
  input  logic                        m_pixel_axis_tready,
  output logic [PIXEL_WIDTH-1:0]      m_pixel_axis_tdata,
  output logic                        m_pixel_axis_tlast,
  output logic                        m_pixel_axis_tuser,
  output logic                        frame_error
);

  localparam int PPW    = pixels_per_word(CMD_STREAM_WIDTH, PIXEL_WIDTH);
  localparam int SLOT_W = (PPW > 1) ? $clog2(PPW) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(PPW - 1);

  unpack_state_t                    state_q, state_d;
  logic [PPW-1:0][PIXEL_WIDTH-1:0]  word_p0;
  logic [SLOT_W-1:0]                slot_p0;
  logic                             last_p0;
  logic                             vld_p0;
  logic                             err_q;

  logic in_hs, out_hs, last_slot;
  logic at_line_end, at_frame_start, at_frame_end;
  logic resync, early_last, missing_last;

  assign vld_p0    = (state_q == STREAM);
  assign last_slot = (slot_p0 == SLOT_LAST);
  assign out_hs    = vld_p0 && m_pixel_axis_tready;
  // Refill is allowed in the same cycle the final slot drains, so no bubble.
  assign s_framebuffer_axis_tready = !rst && (!vld_p0 || (out_hs && last_slot));
  assign in_hs     = s_framebuffer_axis_tvalid && s_framebuffer_axis_tready;

  assign early_last   = out_hs && last_slot && last_p0 && !at_frame_end;
  assign missing_last = out_hs && at_frame_end && !last_p0;
  assign resync       = early_last;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_hs) state_d = STREAM;
      STREAM:  if (out_hs && last_slot && !in_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      state_q <= IDLE;
      slot_p0 <= '0;
      last_p0 <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (in_hs) begin
        slot_p0 <= '0;
        last_p0 <= s_framebuffer_axis_tlast;
      end else if (out_hs && !last_slot) begin
        slot_p0 <= slot_p0 + SLOT_W'(1);
      end
      if (early_last || missing_last) err_q <= 1'b1;
    end
  end

  // Stage p0: captured word; data path is not reset, outputs are gated by valid.
  always_ff @(posedge aclk) begin
    if (in_hs) word_p0 <= s_framebuffer_axis_tdata;
  end

  pixel_position_counter #(
    .X_RESOLUTION(X_RESOLUTION),
    .Y_RESOLUTION(Y_RESOLUTION)
  ) u_pos (
    .aclk          (aclk),
    .rst           (rst),
    .advance       (out_hs),
    .resync        (resync),
    .at_line_end   (at_line_end),
    .at_frame_start(at_frame_start),
    .at_frame_end  (at_frame_end)
  );

  assign m_pixel_axis_tvalid = vld_p0;
  assign m_pixel_axis_tdata  = vld_p0 ? word_p0[slot_p0] : '0;
  assign m_pixel_axis_tlast  = vld_p0 && at_line_end;
  assign m_pixel_axis_tuser  = vld_p0 && at_frame_start;
  assign frame_error         = err_q;

endmodule

// File: doc/framebuffer_stream_unpacker.md
FRAMEBUFFER_STREAM_UNPACKER -- requirements
Module: framebuffer_stream_unpacker

Interface
REQ-001 SHALL have parameter CMD_STREAM_WIDTH, default 32, width of the incoming framebuffer stream word.
REQ-002 SHALL have parameter PIXEL_WIDTH, default 16, width of one RGB565 pixel; CMD_STREAM_WIDTH is an integer multiple of it.
REQ-003 SHALL have parameter X_RESOLUTION, default 128, pixels per line.
REQ-004 SHALL have parameter Y_RESOLUTION, default 128, lines per frame.
REQ-005 SHALL have port aclk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have ports s_framebuffer_axis_tvalid/tready/tlast  in/out/in  1 each  framebuffer AXIS input from RRX.
REQ-008 SHALL have port s_framebuffer_axis_tdata  input  CMD_STREAM_WIDTH  packed pixels, lowest pixel first.
REQ-009 SHALL have ports m_pixel_axis_tvalid/tready  out/in  1  pixel AXIS output handshake.
REQ-010 SHALL have port m_pixel_axis_tdata  output  PIXEL_WIDTH  one pixel.
REQ-011 SHALL have port m_pixel_axis_tlast  output  1  last pixel of a line.
REQ-012 SHALL have port m_pixel_axis_tuser  output  1  first pixel of a frame.
REQ-013 SHALL have port frame_error  output  1  sticky, input tlast misaligned with frame end.

Function
REQ-014 SHALL hold one input word in a data register with a slot counter 0..PPW-1, PPW = CMD_STREAM_WIDTH/PIXEL_WIDTH.
REQ-015 SHALL assert s_framebuffer_axis_tready when register empty, or when the last slot is being accepted downstream in the same cycle (zero-bubble refill).
REQ-016 SHALL present the first pixel of an accepted word on the cycle after acceptance (latency 1); sustained throughput one pixel per cycle.
REQ-017 SHALL emit slot k as tdata = word[k*PIXEL_WIDTH +: PIXEL_WIDTH].
REQ-018 SHALL keep tdata/tlast/tuser stable while m_pixel_axis_tvalid high and tready low.
REQ-019 SHALL count x 0..X_RESOLUTION-1 and y 0..Y_RESOLUTION-1 on each output handshake; x wraps to 0 and y increments at x = X_RESOLUTION-1; y wraps at frame end.
REQ-020 SHALL drive tlast = (x == X_RESOLUTION-1) and tuser = (x == 0 && y == 0).
REQ-021 SHALL capture input tlast with the word; it is expected exactly on the word holding the frame's final pixel.
REQ-022 SHALL, if captured tlast is set on any other word, set frame_error and force x,y to 0 after that word's last slot is sent (resync).
REQ-023 SHALL, if the frame's final pixel is sent without captured tlast, set frame_error and wrap counters normally.
REQ-024 SHALL clear frame_error only by reset.
REQ-025 SHALL use states IDLE (register empty), STREAM (register valid); IDLE->STREAM on input handshake; STREAM->IDLE on last-slot handshake without simultaneous refill.

Reset
REQ-026 SHALL on rst set s_tready 0 for that cycle then 1 in IDLE, m_tvalid 0, tdata 0, tlast 0, tuser 0, x=y=0, slot=0, frame_error 0.
REQ-027 SHALL on rst mid-frame discard held word and restart at pixel (0,0).

Structure
REQ-028 SHALL place the state encoding and a PPW-derive function in shared package rrx_stream_pkg.
REQ-029 SHALL be a single module with one sub-module, pixel_position_counter (x/y counters, tlast/tuser generation).

Verification
REQ-030 Reset, then word 0xBBBBAAAA with tready=1 -> pixels 0xAAAA (tuser=1) then 0xBBBB on consecutive cycles.
REQ-031 Continuous input, tready=1, full 128x128 frame (8192 words, tlast on last) -> 16384 pixels, tlast every 128th, no gaps, frame_error=0.
REQ-032 Downstream tready toggled 1-0-1 each cycle -> no pixel lost/duplicated, outputs stable while stalled.
REQ-033 Input tlast on word 10 -> frame_error=1, pixel after word 10's second pixel carries tuser=1.
REQ-034 Assert rst after 300 pixels, then send new frame -> first pixel tuser=1, counters from (0,0), frame_error=0.
